serial_nibble_collector: RTL and testbench

//   Downstream consumer of the 4-bit serial shift chain output (D).

---
 rtl/serial_nibble_collector_pkg.sv | 28 ++
 rtl/serial_nibble_collector_sipo_shift.sv | 44 ++++
 rtl/serial_nibble_collector.sv | 154 +++++++++++++++
 tb/tb_serial_nibble_collector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_collector_pkg.sv
// ============================================================================
// Module  : ser_pkg
// Brief   : Shared frame states, framing bit levels and counter sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT     = 1'b1;
    localparam logic STOP_BIT      = 1'b0;
    localparam int   DEFAULT_WIDTH = 4;
    localparam int   CNT_W         = (DEFAULT_WIDTH > 1) ? $clog2(DEFAULT_WIDTH) : 1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_nibble_collector_sipo_shift.sv
// ============================================================================
// Module  : sipo_shift
// Brief   : Serial-in parallel-out register, new bits enter at the MSB.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_q <= '0;
                end else if (en) begin
                    r_q <= sin;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_q <= '0;
                end else if (en) begin
                    r_q <= {sin, r_q[WIDTH-1:1]};
                end
            end
        end
    endgenerate

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_nibble_collector.sv
// ============================================================================
// Module  : serial_nibble_collector
// Brief   : Frames start/data/stop serial stream into words on valid/ready.
//           Optional even-parity bit enabled by macro PARITY_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_nibble_collector
    import ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int                 C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_shift_en;
    logic               w_stop_sample;
    logic               w_par_ok;
    logic               w_good;
    logic               w_bad;
    logic               w_load;
    logic               w_drop;
    logic [WIDTH-1:0]   w_data;
    logic [WIDTH-1:0]   r_dout;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk (clk),
        .clr (clr),
        .en  (w_shift_en),
        .sin (sin),
        .q   (w_data)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_en    = 1'b0;
        w_stop_sample = 1'b0;
        if (bit_en) begin
            case (r_state)
                IDLE: begin
                    if (sin == START_BIT) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    w_state_nxt = STOP;
`else
                    w_state_nxt = IDLE;
`endif
                end
                STOP: begin
                    // A stop bit of 1 is an error, never a new start bit.
                    w_stop_sample = 1'b1;
                    w_state_nxt   = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_par;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_par <= 1'b0;
        end else if (bit_en && (r_state == PARITY)) begin
            r_par <= sin;
        end
    end

    assign w_par_ok = ~^{w_data, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_good = w_stop_sample && (sin == STOP_BIT) && w_par_ok;
    assign w_bad  = w_stop_sample && !((sin == STOP_BIT) && w_par_ok);
    // Loading while the old word leaves keeps dout_valid high with no bubble.
    assign w_load = w_good && (!r_valid || dout_ready);
    assign w_drop = w_good && r_valid && !dout_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_valid     <= w_load | (r_valid & ~dout_ready);
            if (w_load) begin
                r_dout <= w_data;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_collector.sv
// ============================================================================
// Module  : tb_serial_nibble_collector
// Brief   : Directed self-checking bench for serial_nibble_collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_nibble_collector;

    localparam int C_WIDTH = 4;

    logic               clk;
    logic               clr;
    logic               bit_en;
    logic               sin;
    logic [C_WIDTH-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               frame_err;
    logic               overrun;

    int r_checks   = 0;
    int r_failures = 0;

`ifdef PARITY_CHECK_EN
    bit r_par_flip = 1'b0;
`endif

    serial_nibble_collector #(
        .WIDTH (C_WIDTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .bit_en     (bit_en),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks = r_checks + 1;
        if (got !== exp) begin
            r_failures = r_failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        bit_en = 1'b1;
        sin    = b;
        tick();
        bit_en = 1'b0;
        sin    = 1'b0;
    endtask

    task automatic send_body(input logic [C_WIDTH-1:0] d, input int gap);
        send_bit(1'b1, gap);
        for (int i = 0; i < C_WIDTH; i++) send_bit(d[i], gap);
`ifdef PARITY_CHECK_EN
        send_bit((^d) ^ r_par_flip, gap);
`endif
    endtask

    task automatic send_frame(input logic [C_WIDTH-1:0] d, input logic stop, input int gap);
        send_body(d, gap);
        send_bit(stop, gap);
    endtask

    initial begin
        clr        = 1'b1;
        bit_en     = 1'b0;
        sin        = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        clr = 1'b0;
        bit_en = 1'b1;
        sin    = 1'b0;
        repeat (3) tick();
        bit_en = 1'b0;
        check("idle_valid", 32'(dout_valid), 32'h0);

        // Basic frame 1101 with consumer ready.
        dout_ready = 1'b1;
        send_frame(4'hD, 1'b0, 0);
        check("f1_valid", 32'(dout_valid), 32'h1);
        check("f1_dout", 32'(dout), 32'hD);
        check("f1_ferr", 32'(frame_err), 32'h0);
        tick();
        check("f1_accepted", 32'(dout_valid), 32'h0);

        // Bad stop bit, then good frame.
        send_frame(4'h6, 1'b1, 0);
        check("fe_pulse", 32'(frame_err), 32'h1);
        check("fe_valid", 32'(dout_valid), 32'h0);
        tick();
        check("fe_clear", 32'(frame_err), 32'h0);
        send_frame(4'h9, 1'b0, 0);
        check("f9_valid", 32'(dout_valid), 32'h1);
        check("f9_dout", 32'(dout), 32'h9);
        tick();
        check("f9_accepted", 32'(dout_valid), 32'h0);

        // Overrun with consumer stalled.
        dout_ready = 1'b0;
        send_frame(4'h5, 1'b0, 0);
        check("f5_dout", 32'(dout), 32'h5);
        check("f5_ovr", 32'(overrun), 32'h0);
        send_frame(4'hA, 1'b0, 0);
        check("ovr_dout_held", 32'(dout), 32'h5);
        check("ovr_valid", 32'(dout_valid), 32'h1);
        check("ovr_set", 32'(overrun), 32'h1);
        dout_ready = 1'b1;
        tick();
        check("ovr_xfer_valid", 32'(dout_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Reset mid-frame after two data bits.
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("mid_clr_ovr", 32'(overrun), 32'h0);
        check("mid_clr_valid", 32'(dout_valid), 32'h0);
        send_frame(4'h3, 1'b0, 0);
        check("f3_valid", 32'(dout_valid), 32'h1);
        check("f3_dout", 32'(dout), 32'h3);
        tick();

        // Completion coinciding with transfer: no bubble, no overrun.
        dout_ready = 1'b0;
        send_frame(4'h4, 1'b0, 0);
        check("f4_dout", 32'(dout), 32'h4);
        send_body(4'h7, 0);
        dout_ready = 1'b1;
        send_bit(1'b0, 0);
        check("bb_valid", 32'(dout_valid), 32'h1);
        check("bb_dout", 32'(dout), 32'h7);
        check("bb_ovr", 32'(overrun), 32'h0);
        tick();
        check("bb_drain", 32'(dout_valid), 32'h0);

        // Sparse bit strobe, one per three clocks.
        send_frame(4'hC, 1'b0, 2);
        check("fc_valid", 32'(dout_valid), 32'h1);
        check("fc_dout", 32'(dout), 32'hC);
        tick();

`ifdef PARITY_CHECK_EN
        r_par_flip = 1'b0;
        send_frame(4'h7, 1'b0, 0);
        check("par_ok_valid", 32'(dout_valid), 32'h1);
        check("par_ok_dout", 32'(dout), 32'h7);
        check("par_ok_ferr", 32'(frame_err), 32'h0);
        tick();
        r_par_flip = 1'b1;
        send_frame(4'h7, 1'b0, 0);
        check("par_bad_ferr", 32'(frame_err), 32'h1);
        check("par_bad_valid", 32'(dout_valid), 32'h0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule

`default_nettype wire
